// File: rtl/fetch_unit.sv
// In-order instruction fetch front end: tracks the PC of the word returning from a
// synchronous-read instruction memory. Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_AWIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  input  logic [31:0]            imem_dout,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        fire;
  logic [31:0] redirect_target;

  // Byte offset of a redirect target is meaningless for word-aligned fetch.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Everything decode sees comes from registers or the memory output only.
  assign inst_valid = (state_q == RUN) || (state_q == HOLD);
  assign inst_pc    = pc_q;
  assign inst       = imem_dout;
  assign fire       = inst_valid & inst_ready;

  always_comb begin
    next_pc = pc_q;
    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (state_q == BOOT) begin
      next_pc = pc_q;
    end else if (fire) begin
      next_pc = pc_q + 32'd4;
    end else begin
      next_pc = pc_q;
    end
  end

  // While in reset the address must not follow redirect_valid.
  always_comb begin
    imem_addr = next_pc[IMEM_AWIDTH+1:2];
    if (!rst_n) begin
      imem_addr = RESET_PC[IMEM_AWIDTH+1:2];
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      BOOT: state_next = RUN;
      RUN: begin
        if (inst_valid && !inst_ready && !redirect_valid) begin
          state_next = HOLD;
        end else begin
          state_next = RUN;
        end
      end
      HOLD: begin
        if (inst_ready || redirect_valid) begin
          state_next = RUN;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_next;
      pc_q    <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // A fire in the same cycle as a redirect is a killed slot, not a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fire && !redirect_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (state_q == HOLD) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner
// sequences and randomized traffic against a slot-level reference model.
module tb_fetch_unit;

  localparam int          AW  = 14;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .IMEM_AWIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Memory word k holds 0x13 + k; one-cycle read latency.
  function automatic logic [31:0] word_idx(input logic [31:0] pc);
    return (pc >> 2) & ((32'd1 << AW) - 32'd1);
  endfunction

  always @(posedge clk) imem_dout <= 32'h0000_0013 + 32'(imem_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: which slot is on the decode port, plus counters.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_stalling;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  typedef struct {
    logic        rd;
    logic [31:0] rp;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_next(input logic rd, input logic [31:0] rp, input logic rdy);
    if (rd) return rp & 32'hFFFF_FFFC;
    if (m_valid && rdy) return m_pc + 32'd4;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_valid    = 1'b0;
    m_pc       = RPC;
    m_stalling = 1'b0;
    m_fetch    = 32'd0;
    m_stall    = 32'd0;
  endtask

  task automatic drive(input logic rd, input logic [31:0] rp, input logic rdy);
    redirect_valid = rd;
    redirect_pc    = rp;
    inst_ready     = rdy;
    #1;
  endtask

  task automatic check_model();
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    if (m_valid) begin
      chk("inst_pc", inst_pc, m_pc);
      chk("inst", inst, 32'h0000_0013 + word_idx(m_pc));
    end
    chk("imem_addr", 32'(imem_addr),
        word_idx(model_next(redirect_valid, redirect_pc, inst_ready)));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic adv();
    logic [31:0] nxt;
    nxt = model_next(redirect_valid, redirect_pc, inst_ready);
    if (m_stalling) m_stall = m_stall + 32'd1;
    if (m_valid && inst_ready && !redirect_valid) m_fetch = m_fetch + 32'd1;
    m_stalling = m_valid && !inst_ready && !redirect_valid;
    m_valid    = 1'b1;
    m_pc       = nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0700, 1'b1);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), word_idx(RPC));
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("reset released at %0t", $time);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b0;
    model_reset();

    //          rd    rp            rdy   v     pc            addr
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h1};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h2};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h2};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h2};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h2};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h3};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h4};
    tbl[8]  = '{1'b1, 32'h103,      1'b1, 1'b1, 32'h10,       32'h40};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h41};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h104,      32'h41};
    tbl[11] = '{1'b1, 32'h300,      1'b0, 1'b1, 32'h104,      32'hC0};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      32'hC0};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      32'hC1};
    tbl[14] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h304,     32'h3FFF};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rd, tbl[i].rp, tbl[i].rdy);
      $display("vec %0d rd=%0b rdy=%0b valid=%0b pc=%h addr=%h",
               i, tbl[i].rd, tbl[i].rdy, inst_valid, inst_pc, imem_addr);
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk("tbl_pc", inst_pc, tbl[i].pc);
      chk("tbl_addr", 32'(imem_addr), tbl[i].addr);
      check_model();
      adv();
    end

    // Redirect in the BOOT cycle.
    do_reset();
    drive(1'b1, 32'h0000_0200, 1'b0);
    chk("boot_rd_addr", 32'(imem_addr), 32'h80);
    check_model();
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("boot_rd_valid", 32'(inst_valid), 32'd1);
    chk("boot_rd_pc", inst_pc, 32'h200);
    check_model();
    adv();
    $display("boot redirect: pc=%h", inst_pc);

    // Reset pulse in the middle of a HOLD at 0x40.
    drive(1'b1, 32'h0000_0040, 1'b1);
    check_model();
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      check_model();
      adv();
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("hold_pc", inst_pc, 32'h40);
    #2;
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_addr", 32'(imem_addr), word_idx(RPC));
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_fetch", perf_fetch_cnt, 32'd0);
    chk("midrst_stall", perf_stall_cnt, 32'd0);
`endif
    redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 32'h0, 1'b1);
    check_model();
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("post_rst_pc", inst_pc, RPC);
    check_model();
    adv();
    $display("mid-hold reset: pc=%h valid=%0b", inst_pc, inst_valid);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        rd;
      logic [31:0] rp;
      logic        rdy;
      rd  = ($urandom_range(7) == 0);
      rp  = $urandom;
      rdy = ($urandom_range(9) < 7);
      drive(rd, rp, rdy);
      $display("rnd %0d rd=%0b rp=%h rdy=%0b valid=%0b pc=%h addr=%h",
               i, rd, rp, rdy, inst_valid, inst_pc, imem_addr);
      check_model();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
